// File: rtl/program_counter_pkg.sv
// Shared definitions for the program counter core: FSM state encoding and the
// default parameter values used by program_counter and call_stack.
package program_counter_pkg;

  localparam int unsigned DefWordWidth        = 32;
  localparam int unsigned DefProgramAddrWidth = 16;
  localparam int unsigned DefCstackDepth      = 8;

  // StFlush: the instruction at pc is a bubble; StRun: it is valid.
  typedef enum logic {
    StFlush = 1'b0,
    StRun   = 1'b1
  } pc_state_e;

endpackage

// File: rtl/call_stack.sv
// Circular LIFO of return addresses.
//   clk_i    : clock
//   reset_i  : asynchronous active-high reset (empties the stack)
//   push_i   : write data_i on top; when full, the oldest entry is overwritten
//   pop_i    : discard the top entry (ignored when empty or when push_i is set)
//   data_i   : address to push
//   data_o   : current top entry (valid only when empty_o is low)
//   full_o   : Depth entries held
//   empty_o  : no entries held
module call_stack
  import program_counter_pkg::*;
#(
  parameter int unsigned Width = DefProgramAddrWidth,
  parameter int unsigned Depth = DefCstackDepth
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  // sp_q points at the next free slot; it wraps, so a push when full lands on
  // the oldest entry while the count saturates at Depth.
  logic [PtrW-1:0] sp_q, sp_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[sp_q - PtrW'(1)];

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      sp_d = sp_q + PtrW'(1);
      if (!full_o) cnt_d = cnt_q + (PtrW + 1)'(1);
    end else if (pop_i && !empty_o) begin
      sp_d  = sp_q - PtrW'(1);
      cnt_d = cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[sp_q] <= data_i;
  end

endmodule

// File: rtl/program_counter.sv
// Program counter with redirect handling and a return-address call stack.
//   clk_i, reset_i          : clock, asynchronous active-high reset
//   stall_i                 : freeze all state this cycle
//   branch_i                : pc <= pc + sext(branch_offset_i)
//   jump_immediate_i        : pc <= immediate_addr_i
//   jump_stack_i            : pc <= top_i[PW-1:0]
//   call_i                  : push pc+1 onto the call stack
//   ret_i                   : pop the call stack into pc
//   immediate_addr_i        : JMPI/CALLI target
//   top_i                   : data-stack top, low PW bits are the JMP/CALL target
//   branch_offset_i         : signed 8-bit branch displacement
//   pc_o, pc_valid_o        : decode address and its validity (low = bubble)
//   cstack_overflow_o       : sticky, a push hit a full stack
//   cstack_underflow_o      : sticky, a return found the stack empty
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH         = DefWordWidth,
  parameter int unsigned PROGRAM_ADDR_WIDTH = DefProgramAddrWidth,
  parameter int unsigned CSTACK_DEPTH       = DefCstackDepth
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          stall_i,
  input  logic                          branch_i,
  input  logic                          jump_immediate_i,
  input  logic                          jump_stack_i,
  input  logic                          call_i,
  input  logic                          ret_i,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] immediate_addr_i,
  input  logic [WORD_WIDTH-1:0]         top_i,
  input  logic [7:0]                    branch_offset_i,
  output logic [PROGRAM_ADDR_WIDTH-1:0] pc_o,
  output logic                          pc_valid_o,
  output logic                          cstack_overflow_o,
  output logic                          cstack_underflow_o
);

  localparam int unsigned PW = PROGRAM_ADDR_WIDTH;

  pc_state_e       state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            run_en;
  logic            take_ret, ret_ok, ret_bad, redirect;
  logic            push, pop;
  logic            cs_full, cs_empty;
  logic [PW-1:0]   cs_top;
  logic [PW-1:0]   pc_inc, pc_branch;

  // Only bits [PW-1:0] of the data-stack top form an address.
  if (WORD_WIDTH > PW) begin : g_top_unused
    logic unused_top_bits;
    assign unused_top_bits = ^top_i[WORD_WIDTH-1:PW];
  end

  assign run_en    = (state_q == StRun) && !stall_i;
  assign pc_inc    = pc_q + PW'(1);
  assign pc_branch = pc_q + {{(PW - 8){branch_offset_i[7]}}, branch_offset_i};

  // A return is only taken when nothing of higher priority redirects and no
  // call is present in the same instruction (the call wins).
  assign take_ret = ret_i && !call_i && !jump_stack_i && !jump_immediate_i && !branch_i;
  assign ret_ok   = take_ret && !cs_empty;
  assign ret_bad  = take_ret && cs_empty;
  assign redirect = jump_stack_i || jump_immediate_i || branch_i || ret_ok;

  assign push = run_en && call_i;
  assign pop  = run_en && ret_ok;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StFlush;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      unique case (state_q)
        StFlush: state_d = StRun;
        StRun:   state_d = redirect ? StFlush : StRun;
        default: state_d = StFlush;
      endcase
    end
  end

  // Datapath next values. FLUSH holds the pc it was given, so the redirect
  // target (or address 0 after reset) becomes the first valid pc.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (run_en) begin
      if (jump_stack_i)          pc_d = top_i[PW-1:0];
      else if (jump_immediate_i) pc_d = immediate_addr_i;
      else if (branch_i)         pc_d = pc_branch;
      else if (ret_ok)           pc_d = cs_top;
      else                       pc_d = pc_inc;
      if (call_i && cs_full) ovf_d = 1'b1;
      if (ret_bad)           unf_d = 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    pc_o               = pc_q;
    pc_valid_o         = (state_q == StRun);
    cstack_overflow_o  = ovf_q;
    cstack_underflow_o = unf_q;
  end

  call_stack #(
    .Width (PW),
    .Depth (CSTACK_DEPTH)
  ) u_call_stack (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .data_o  (cs_top),
    .full_o  (cs_full),
    .empty_o (cs_empty)
  );

endmodule
